traffic_phase_ctrl: RTL and testbench
=====================================

// Module: traffic_phase_ctrl
// PURPOSE
//  Two-road intersection lamp controller. Sequences road A and road B through green, yellow
//  and all-red phases, with per-phase dwell times set by parameters and counted in tick pulses.
//  Adds a latched pedestrian walk phase and a flashing-yellow override.
//  Sits between the timebase divider (tick) and the lamp drivers.
// PARAMETERS
//  CNT_W        8  dwell counter width
//  GREEN_TICKS  4  ticks per green phase (>=1, < 2**CNT_W)
//  YELLOW_TICKS 2  ticks per yellow phase (>=1)
//  ALLRED_TICKS 1  ticks per all-red clearance phase (>=1)
//  PED_TICKS    3  ticks per pedestrian walk phase (>=1)
// PORTS
//  clock     in   1      rising-edge clock
//  reset     in   1      asynchronous, active-high reset
//  tick      in   1      dwell-count enable, one clock wide; state advances only on tick
//  ped_req   in   1      pedestrian request, any width; latched
//  flash_req in   1      level; high forces flashing-yellow mode
//  light_a   out  [0:2]  road A lamps: RED=3'b100 GREEN=3'b010 YELLOW=3'b001 OFF=3'b000
//  light_b   out  [0:2]  road B lamps, same encoding
//  ped_walk  out  1      walk signal, high only in PED
//  phase     out  3      current state code (see below)
// BEHAVIOUR
//  States/phase code: A_GRN=0 A_YEL=1 AR1=2 B_GRN=3 B_YEL=4 AR2=5 PED=6 FLASH=7.
//  All outputs are registered Moore outputs. They update on the same edge as the state.
//  Reset: state=AR2, cnt=ALLRED_TICKS-1, light_a=light_b=RED, ped_walk=0, ped_pend=0, flash_ph=0.
//  Dwell: on entry to a state, cnt is loaded with DUR-1.
//   - tick=1 and cnt!=0: cnt decrements.
//   - tick=1 and cnt==0: transition taken and next DUR-1 loaded.
//   - tick=0: everything holds.
//  Normal cycle: A_GRN -> A_YEL -> AR1 -> B_GRN -> B_YEL -> AR2 -> A_GRN.
//  Lamps per state:
//   - A_GRN: A=GREEN, B=RED.
//   - A_YEL: A=YELLOW, B=RED.
//   - B_GRN: A=RED, B=GREEN.
//   - B_YEL: A=RED, B=YELLOW.
//   - AR1, AR2, PED: both RED.
//  Pedestrian:
//   - ped_req=1 on any edge sets ped_pend (sticky).
//   - AR2 expiry with ped_pend=1 -> PED, not A_GRN. On that entry edge ped_pend clears;
//     clear wins over a simultaneous ped_req.
//   - PED: ped_walk=1, both lamps RED, dwell PED_TICKS. Expiry -> A_GRN.
//   - ped_req during PED sets ped_pend again; it is served on the next AR2.
//  Flash:
//   - flash_req=1 at an edge -> FLASH on that edge from any state. Does not wait for tick
//     or dwell expiry.
//   - On entry: flash_ph=1, lamps YELLOW, ped_walk=0.
//   - In FLASH, each tick toggles flash_ph. Both lamps show YELLOW when flash_ph=1, OFF when 0.
//   - flash_req=0 at an edge while in FLASH -> AR2 with cnt=ALLRED_TICKS-1, both RED,
//     then the normal cycle resumes. ped_pend is retained across FLASH.
//   - flash_req has priority over every dwell/ped transition on the same edge.
//  Safety invariant: outside FLASH, at least one road is RED at all times.
//  OFF appears only in FLASH. Unused codes are unreachable; an illegal state recovers to
//  AR2 with both lamps RED.
//  Async reset mid-phase: immediately forces the reset values above. The first tick-counted
//  state after release is AR2.
//  Width: cnt is CNT_W bits unsigned, with no wrap (loads always < 2**CNT_W).
// TESTING  (defaults, tick tied high unless noted)
//  1) Release reset, run 28 clocks -> phase sequence 5,0x4,1x2,2,3x4,4x2,5,
//     i.e. period 14 with exact lamp codes. Two full cycles checked.
//  2) tick pulsed every 3rd clock -> every dwell stretches x3 and lamps hold between ticks;
//     cnt never decrements without tick.
//  3) One-clock ped_req during B_GRN -> after B_YEL and AR2, PED for 3 clocks with ped_walk=1
//     and both RED, then A_GRN. The following cycle has no PED.
//  4) ped_req on the AR2->PED entry edge -> no second PED; ped_req during PED -> PED repeats
//     on the next cycle.
//  5) flash_req=1 mid A_GRN -> next edge FLASH: lamps 001,000,001... per tick, ped_walk=0.
//     Drop flash_req -> AR2 for 1 tick, then A_GRN.
//  6) Assert reset during B_YEL with tick=0 -> outputs become RED/RED, phase=5 with no
//     clock edge. Invariant checker passes throughout.

Source files
------------

// File: rtl/traffic_phase_ctrl_if.sv
// Lamp-controller bus: timebase/request inputs and registered lamp outputs.
//  master : drives tick, ped_req, flash_req; observes lamps, walk and phase
//  slave  : the controller side
interface traffic_phase_ctrl_if;
  logic       tick;
  logic       ped_req;
  logic       flash_req;
  logic [0:2] light_a;
  logic [0:2] light_b;
  logic       ped_walk;
  logic [2:0] phase;

  modport master (
    output tick, ped_req, flash_req,
    input  light_a, light_b, ped_walk, phase
  );

  modport slave (
    input  tick, ped_req, flash_req,
    output light_a, light_b, ped_walk, phase
  );
endinterface

// File: rtl/traffic_phase_ctrl.sv
// Two-road intersection lamp controller with latched pedestrian phase and
// flashing-yellow override. Dwell times are counted in tick pulses.
//  clock : rising-edge clock
//  reset : asynchronous active-high reset
//  bus   : tick / ped_req / flash_req in; light_a / light_b / ped_walk / phase out
module traffic_phase_ctrl #(
  parameter int unsigned CNT_W        = 8,
  parameter int unsigned GREEN_TICKS  = 4,
  parameter int unsigned YELLOW_TICKS = 2,
  parameter int unsigned ALLRED_TICKS = 1,
  parameter int unsigned PED_TICKS    = 3
) (
  input  logic                 clock,
  input  logic                 reset,
  traffic_phase_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    A_GRN = 3'd0,
    A_YEL = 3'd1,
    AR1   = 3'd2,
    B_GRN = 3'd3,
    B_YEL = 3'd4,
    AR2   = 3'd5,
    PED   = 3'd6,
    FLASH = 3'd7
  } state_t;

  localparam logic [0:2] LAMP_RED = 3'b100;
  localparam logic [0:2] LAMP_GRN = 3'b010;
  localparam logic [0:2] LAMP_YEL = 3'b001;
  localparam logic [0:2] LAMP_OFF = 3'b000;

  localparam logic [CNT_W-1:0] LOAD_GRN = CNT_W'(GREEN_TICKS - 1);
  localparam logic [CNT_W-1:0] LOAD_YEL = CNT_W'(YELLOW_TICKS - 1);
  localparam logic [CNT_W-1:0] LOAD_AR  = CNT_W'(ALLRED_TICKS - 1);
  localparam logic [CNT_W-1:0] LOAD_PED = CNT_W'(PED_TICKS - 1);

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             ped_pend, ped_pend_n;
  logic             flash_ph, flash_ph_n;
  logic [0:2]       lamp_a, lamp_a_n;
  logic [0:2]       lamp_b, lamp_b_n;
  logic             walk, walk_n;

  // Dwell reload value for a normal-cycle state.
  function automatic logic [CNT_W-1:0] dwell_load(input state_t s);
    case (s)
      A_GRN, B_GRN: dwell_load = LOAD_GRN;
      A_YEL, B_YEL: dwell_load = LOAD_YEL;
      PED:          dwell_load = LOAD_PED;
      default:      dwell_load = LOAD_AR;
    endcase
  endfunction

  // Lamp/walk word {a, b, walk} for a normal-cycle state; FLASH is handled separately.
  function automatic logic [6:0] lamp_word(input state_t s);
    case (s)
      A_GRN:   lamp_word = {LAMP_GRN, LAMP_RED, 1'b0};
      A_YEL:   lamp_word = {LAMP_YEL, LAMP_RED, 1'b0};
      B_GRN:   lamp_word = {LAMP_RED, LAMP_GRN, 1'b0};
      B_YEL:   lamp_word = {LAMP_RED, LAMP_YEL, 1'b0};
      PED:     lamp_word = {LAMP_RED, LAMP_RED, 1'b1};
      default: lamp_word = {LAMP_RED, LAMP_RED, 1'b0};
    endcase
  endfunction

  // State, dwell counter and registered Moore outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= AR2;
      cnt      <= LOAD_AR;
      ped_pend <= 1'b0;
      flash_ph <= 1'b0;
      lamp_a   <= LAMP_RED;
      lamp_b   <= LAMP_RED;
      walk     <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      ped_pend <= ped_pend_n;
      flash_ph <= flash_ph_n;
      lamp_a   <= lamp_a_n;
      lamp_b   <= lamp_b_n;
      walk     <= walk_n;
    end
  end

  // Next state and next outputs; flash override beats dwell/ped transitions.
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    ped_pend_n = ped_pend | bus.ped_req;
    flash_ph_n = flash_ph;
    lamp_a_n   = lamp_a;
    lamp_b_n   = lamp_b;
    walk_n     = walk;

    if (bus.flash_req) begin
      state_n = FLASH;
      if (state != FLASH) begin
        flash_ph_n = 1'b1;
      end else if (bus.tick) begin
        flash_ph_n = ~flash_ph;
      end
      lamp_a_n = flash_ph_n ? LAMP_YEL : LAMP_OFF;
      lamp_b_n = flash_ph_n ? LAMP_YEL : LAMP_OFF;
      walk_n   = 1'b0;
    end else if (state == FLASH) begin
      // Leaving flash always goes through a full all-red clearance.
      state_n    = AR2;
      cnt_n      = LOAD_AR;
      flash_ph_n = 1'b0;
      lamp_a_n   = LAMP_RED;
      lamp_b_n   = LAMP_RED;
      walk_n     = 1'b0;
    end else if (bus.tick) begin
      if (cnt != '0) begin
        cnt_n = cnt - CNT_W'(1);
      end else begin
        case (state)
          A_GRN: state_n = A_YEL;
          A_YEL: state_n = AR1;
          AR1:   state_n = B_GRN;
          B_GRN: state_n = B_YEL;
          B_YEL: state_n = AR2;
          AR2: begin
            if (ped_pend) begin
              state_n    = PED;
              ped_pend_n = 1'b0;
            end else begin
              state_n = A_GRN;
            end
          end
          PED:     state_n = A_GRN;
          default: state_n = AR2;
        endcase
        cnt_n                      = dwell_load(state_n);
        {lamp_a_n, lamp_b_n, walk_n} = lamp_word(state_n);
      end
    end
  end

  assign bus.light_a  = lamp_a;
  assign bus.light_b  = lamp_b;
  assign bus.ped_walk = walk;
  assign bus.phase    = state;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Scoreboard bench for traffic_phase_ctrl: stimulus pushes the expected
// post-edge outputs, a monitor pops and compares after every rising edge.
module tb_traffic_phase_ctrl;

  typedef struct packed {
    logic [2:0] ph;
    logic [0:2] la;
    logic [0:2] lb;
    logic       pw;
  } exp_t;

  localparam logic [0:2] RED = 3'b100;
  localparam logic [0:2] GRN = 3'b010;
  localparam logic [0:2] YEL = 3'b001;
  localparam logic [0:2] OFF = 3'b000;

  logic clock;
  logic reset;
  traffic_phase_ctrl_if bus();

  traffic_phase_ctrl dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int   total;
  int   bad;
  int   mon_n;
  exp_t q[$];
  int   base[14] = '{0, 0, 0, 0, 1, 1, 2, 3, 3, 3, 3, 4, 4, 5};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Expected outputs for a phase code, from the lamp table.
  function automatic exp_t exp_of(input int ph, input bit fy);
    exp_t e;
    e.ph = 3'(ph);
    e.pw = (ph == 6);
    case (ph)
      0:       begin e.la = GRN; e.lb = RED; end
      1:       begin e.la = YEL; e.lb = RED; end
      3:       begin e.la = RED; e.lb = GRN; end
      4:       begin e.la = RED; e.lb = YEL; end
      7:       begin e.la = fy ? YEL : OFF; e.lb = fy ? YEL : OFF; end
      default: begin e.la = RED; e.lb = RED; end
    endcase
    return e;
  endfunction

  function automatic exp_t act();
    exp_t a;
    a.ph = bus.phase;
    a.la = bus.light_a;
    a.lb = bus.light_b;
    a.pw = bus.ped_walk;
    return a;
  endfunction

  task automatic cmp(input string name, input exp_t a, input exp_t e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got ph=%0d a=%b b=%b walk=%b, need ph=%0d a=%b b=%b walk=%b",
               name, a.ph, a.la, a.lb, a.pw, e.ph, e.la, e.lb, e.pw);
    end
  endtask

  // Drive inputs for the next rising edge and queue the outputs expected after it.
  task automatic step(input bit t, input bit p, input bit f, input int ph, input bit fy);
    @(negedge clock);
    bus.tick      = t;
    bus.ped_req   = p;
    bus.flash_req = f;
    q.push_back(exp_of(ph, fy));
  endtask

  // One normal cycle from AR2 with cnt=0, tick high, optional PED tail and ped pulses.
  task automatic cycle(input bit with_ped, input int pa, input int pb);
    int n;
    n = with_ped ? 17 : 14;
    for (int i = 0; i < n; i++) begin
      step(1'b1, (i == pa) || (i == pb), 1'b0, (i < 14) ? base[i] : 6, 1'b0);
    end
  endtask

  // Scoreboard monitor.
  always @(posedge clock) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      mon_n++;
      cmp($sformatf("edge%0d", mon_n), act(), e);
    end
  end

  // Safety invariant: outside flash one road is red and nothing is dark.
  always @(negedge clock) begin
    if (!reset) begin
      total++;
      if (bus.phase != 3'd7 &&
          ((bus.light_a != RED && bus.light_b != RED) ||
           bus.light_a == OFF || bus.light_b == OFF)) begin
        bad++;
        $display("FAIL invariant: got ph=%0d a=%b b=%b, need one road RED and no OFF",
                 bus.phase, bus.light_a, bus.light_b);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, need $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    total         = 0;
    bad           = 0;
    mon_n         = 0;
    reset         = 1'b1;
    bus.tick      = 1'b0;
    bus.ped_req   = 1'b0;
    bus.flash_req = 1'b0;
    #1;
    cmp("reset_state", act(), exp_of(5, 1'b0));
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;

    // Normal cycle, tick every clock, two periods.
    cycle(1'b0, -1, -1);
    cycle(1'b0, -1, -1);

    // Tick every third clock: each dwell stretches x3.
    for (int i = 0; i < 42; i++) begin
      step(i % 3 == 0, 1'b0, 1'b0, base[i / 3], 1'b0);
    end

    // Ped request in B_GRN served after AR2, then no repeat.
    cycle(1'b1, 8, -1);
    cycle(1'b0, -1, -1);

    // Request on the PED entry edge is swallowed.
    cycle(1'b1, 8, 14);
    cycle(1'b0, -1, -1);

    // Request during PED is served on the next cycle.
    cycle(1'b1, 8, 15);
    cycle(1'b1, -1, -1);

    // Flash override mid A_GRN, toggling per tick, exit via AR2.
    step(1'b1, 1'b0, 1'b0, 0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 7, 1'b1);
    step(1'b1, 1'b0, 1'b1, 7, 1'b0);
    step(1'b0, 1'b0, 1'b1, 7, 1'b0);
    step(1'b1, 1'b0, 1'b1, 7, 1'b1);
    step(1'b1, 1'b0, 1'b1, 7, 1'b0);
    step(1'b1, 1'b0, 1'b0, 5, 1'b0);
    step(1'b1, 1'b0, 1'b0, 0, 1'b0);

    // Ped request latched during flash survives into the next AR2.
    step(1'b1, 1'b0, 1'b1, 7, 1'b1);
    step(1'b1, 1'b1, 1'b1, 7, 1'b0);
    step(1'b1, 1'b0, 1'b0, 5, 1'b0);
    step(1'b1, 1'b0, 1'b0, 6, 1'b0);
    step(1'b1, 1'b0, 1'b0, 6, 1'b0);
    step(1'b1, 1'b0, 1'b0, 6, 1'b0);
    step(1'b1, 1'b0, 1'b0, 0, 1'b0);

    // Walk into B_YEL, then async reset with tick low.
    for (int i = 1; i < 12; i++) begin
      step(1'b1, 1'b0, 1'b0, base[i], 1'b0);
    end
    @(negedge clock);
    bus.tick = 1'b0;
    @(posedge clock);
    #2;
    cmp("pre_reset_hold", act(), exp_of(4, 1'b0));
    reset = 1'b1;
    #1;
    cmp("async_reset", act(), exp_of(5, 1'b0));
    bus.tick = 1'b1;
    @(posedge clock);
    @(posedge clock);
    #1;
    cmp("reset_held", act(), exp_of(5, 1'b0));
    @(negedge clock);
    reset    = 1'b0;
    bus.tick = 1'b0;
    step(1'b1, 1'b0, 1'b0, 0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 0, 1'b0);

    @(negedge clock);
    bus.tick = 1'b0;
    @(posedge clock);
    #3;
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d queued, need 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
